pll_reset_seq: RTL and testbench

Consumer side of the PLL lock interface: watches the PLL `locked` output and produces the design's system reset. Reset is released only after lock has been stable for a qualification window. The block:
- re-asserts reset on lock loss;
- pulses the PLL RST input if lock never arrives;
- counts lock-loss events.

It runs on the free-running 25 MHz board clock, because clkout0 is not trustworthy before lock. Each fast-domain consumer synchronizes `sys_rst_n` locally.

---
 rtl/clocks_pkg.sv | 27 ++
 rtl/sync_bit.sv | 21 ++
 rtl/pll_reset_seq.sv | 103 ++++++++++
 tb/tb_pll_reset_seq.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clocks_pkg.sv
// Shared clocking types: reset-sequencer state encoding
// and the counter-width helper.
package clocks_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STABLE    = 3'd1,
    RUN       = 3'd2,
    SOFT_RST  = 3'd3,
    PLL_RST   = 3'd4
  } rst_state_e;

  function automatic int cnt_width(
    input int a,
    input int b,
    input int c,
    input int d
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_bit.sv
// N-stage single-bit synchronizer for asynchronous
// status inputs, async active-low reset.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/pll_reset_seq.sv
// PLL lock qualifier and system reset sequencer,
// clocked from the free-running board clock.
module pll_reset_seq
  import clocks_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int STABLE_CYCLES   = 1024,
  parameter int LOCK_TIMEOUT    = 65536,
  parameter int PLLRST_CYCLES   = 16,
  parameter int SOFT_RST_CYCLES = 32,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             locked_async,
  input  logic             soft_rst_req,
  output logic             sys_rst_n,
  output logic             pll_rst,
  output logic [CNT_W-1:0] lock_loss_cnt,
  output logic [2:0]       state_o
);

  localparam int CW = cnt_width(STABLE_CYCLES,
    LOCK_TIMEOUT, PLLRST_CYCLES, SOFT_RST_CYCLES);

  localparam logic [CW-1:0] LT_END = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] SC_END = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] PR_END = CW'(PLLRST_CYCLES - 1);
  localparam logic [CW-1:0] SR_END = CW'(SOFT_RST_CYCLES - 1);

  logic       lock_s;
  rst_state_e state_q;
  rst_state_e state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic       loss;

  sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (locked_async),
    .q    (lock_s)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_LOCK: begin
        if (lock_s)               state_d = STABLE;
        else if (cnt_q == LT_END) state_d = PLL_RST;
      end
      STABLE: begin
        if (!lock_s)              state_d = WAIT_LOCK;
        else if (cnt_q == SC_END) state_d = RUN;
      end
      RUN: begin
        if (!lock_s)           state_d = WAIT_LOCK;
        else if (soft_rst_req) state_d = SOFT_RST;
      end
      SOFT_RST: begin
        if (!lock_s)              state_d = WAIT_LOCK;
        else if (cnt_q == SR_END) state_d = STABLE;
      end
      PLL_RST: begin
        if (cnt_q == PR_END) state_d = WAIT_LOCK;
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  // counter restarts on every transition; RUN has no dwell
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (state_d != state_q)  cnt_d = '0;
    else if (state_q == RUN) cnt_d = cnt_q;
  end

  assign loss = (state_q == RUN) && !lock_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      lock_loss_cnt <= '0;
    else if (loss && lock_loss_cnt != '1)
      lock_loss_cnt <= lock_loss_cnt + CNT_W'(1);
  end

  assign sys_rst_n = (state_q == RUN);
  assign pll_rst   = (state_q == PLL_RST);
  assign state_o   = state_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Randomized scoreboard bench for pll_reset_seq against
// a dwell-countdown reference model.
module tb_pll_reset_seq;

  localparam int SS = 2;
  localparam int SC = 8;
  localparam int LT = 100;
  localparam int PR = 4;
  localparam int SR = 5;
  localparam int CW = 2;

  localparam int M_WAIT   = 0;
  localparam int M_STABLE = 1;
  localparam int M_RUN    = 2;
  localparam int M_SOFT   = 3;
  localparam int M_PLL    = 4;

  typedef struct packed {
    logic          srn;
    logic          prst;
    logic [2:0]    st;
    logic [CW-1:0] cnt;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          locked_async = 1'b0;
  logic          soft_rst_req = 1'b0;
  logic          sys_rst_n;
  logic          pll_rst;
  logic [CW-1:0] lock_loss_cnt;
  logic [2:0]    state_o;

  int n_chk = 0;
  int n_fail = 0;

  obs_t exp_q[$];
  logic syncq[$];
  int   m_mode;
  int   m_rem;
  int   m_loss;

  always #5 clk = ~clk;

  pll_reset_seq #(
    .SYNC_STAGES    (SS),
    .STABLE_CYCLES  (SC),
    .LOCK_TIMEOUT   (LT),
    .PLLRST_CYCLES  (PR),
    .SOFT_RST_CYCLES(SR),
    .CNT_W          (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .locked_async (locked_async),
    .soft_rst_req (soft_rst_req),
    .sys_rst_n    (sys_rst_n),
    .pll_rst      (pll_rst),
    .lock_loss_cnt(lock_loss_cnt),
    .state_o      (state_o)
  );

  task automatic chk(input string name, input int act,
                     input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int dwell(input int m);
    case (m)
      M_WAIT:   return LT;
      M_STABLE: return SC;
      M_SOFT:   return SR;
      M_PLL:    return PR;
      default:  return 0;
    endcase
  endfunction

  task automatic go(input int m);
    m_mode = m;
    m_rem  = dwell(m);
  endtask

  task automatic model_reset();
    syncq.delete();
    for (int i = 0; i < SS; i++) syncq.push_back(1'b0);
    go(M_WAIT);
    m_loss = 0;
  endtask

  task automatic model_edge(input logic lk, input logic sr);
    logic ls;
    ls = syncq.pop_front();
    syncq.push_back(lk);
    case (m_mode)
      M_WAIT:
        if (ls) go(M_STABLE);
        else begin
          m_rem--;
          if (m_rem == 0) go(M_PLL);
        end
      M_STABLE:
        if (!ls) go(M_WAIT);
        else begin
          m_rem--;
          if (m_rem == 0) go(M_RUN);
        end
      M_RUN:
        if (!ls) begin
          go(M_WAIT);
          if (m_loss < (1 << CW) - 1) m_loss++;
        end else if (sr) go(M_SOFT);
      M_SOFT:
        if (!ls) go(M_WAIT);
        else begin
          m_rem--;
          if (m_rem == 0) go(M_STABLE);
        end
      default: begin
        m_rem--;
        if (m_rem == 0) go(M_WAIT);
      end
    endcase
  endtask

  // drive one cycle of inputs at negedge, queue the expected result
  task automatic step(input logic lk, input logic sr);
    obs_t e;
    locked_async = lk;
    soft_rst_req = sr;
    model_edge(lk, sr);
    e.srn  = (m_mode == M_RUN);
    e.prst = (m_mode == M_PLL);
    e.st   = 3'(m_mode);
    e.cnt  = CW'(m_loss);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic hold(input logic lk, input int n);
    for (int i = 0; i < n; i++) step(lk, 1'b0);
  endtask

  task automatic do_reset();
    locked_async = 1'b0;
    soft_rst_req = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_sys_rst_n", int'(sys_rst_n), 0);
    chk("rst_state", int'(state_o), 0);
    model_reset();
    rst_n = 1'b1;
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n && exp_q.size() > 0) begin
      obs_t e;
      obs_t a;
      e = exp_q.pop_front();
      a = {sys_rst_n, pll_rst, state_o, lock_loss_cnt};
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t: got srn=%b prst=%b st=%0d cnt=%0d expected srn=%b prst=%b st=%0d cnt=%0d",
          $time, a.srn, a.prst, a.st, a.cnt,
          e.srn, e.prst, e.st, e.cnt);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic lk;
    #12;
    chk("init_sys_rst_n", int'(sys_rst_n), 0);
    chk("init_pll_rst", int'(pll_rst), 0);
    chk("init_state", int'(state_o), 0);
    chk("init_cnt", int'(lock_loss_cnt), 0);
    @(negedge clk);
    do_reset();

    // lock up, then build up two counted losses
    hold(1'b1, 15);
    chk("run_reached", int'(sys_rst_n), 1);
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 1'b0);
      hold(1'b1, 15);
    end
    chk("loss_two", int'(lock_loss_cnt), 2);

    // async reset mid-RUN, checked before any clock edge
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_sys_rst_n", int'(sys_rst_n), 0);
    chk("async_cnt", int'(lock_loss_cnt), 0);
    chk("async_state", int'(state_o), 0);
    chk("async_pll_rst", int'(pll_rst), 0);
    @(negedge clk);
    do_reset();

    // lock never arrives: two pll_rst pulses
    hold(1'b0, 220);

    // glitch in STABLE, then qualify
    hold(1'b1, 4);
    step(1'b0, 1'b0);
    hold(1'b1, 15);

    // four losses for saturation
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0);
      hold(1'b1, 14);
    end
    chk("loss_sat", int'(lock_loss_cnt), 3);

    // soft reset, then soft request colliding with loss
    step(1'b1, 1'b1);
    hold(1'b1, 16);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    hold(1'b1, 14);

    // random, mostly locked
    do_reset();
    lk = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (lk && $urandom_range(0, 39) == 0) lk = 1'b0;
      else if (!lk && $urandom_range(0, 2) == 0) lk = 1'b1;
      step(lk, 1'($urandom_range(0, 24) == 0));
    end

    // random, mostly unlocked: timeouts with glitches
    for (int i = 0; i < 800; i++) begin
      if (lk && $urandom_range(0, 4) == 0) lk = 1'b0;
      else if (!lk && $urandom_range(0, 59) == 0) lk = 1'b1;
      step(lk, 1'($urandom_range(0, 3) == 0));
    end

    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end

endmodule
